// File: rtl/spi_pkg.sv
// spi_pkg: shared helpers for the word-oriented SPI slave.
// Bit-order aware shift and tap functions on a wide scratch word.
package spi_pkg;

    localparam int MAX_W = 64;
    localparam int IW    = $clog2(MAX_W);

    typedef logic [MAX_W-1:0] word_t;

    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    function automatic logic first_bit(
        input word_t word,
        input int    w,
        input logic  msb_first
    );
        return msb_first ? word[IW'(w-1)] : word[0];
    endfunction

    function automatic word_t shift_out(
        input word_t word,
        input logic  msb_first
    );
        return msb_first ? (word << 1) : (word >> 1);
    endfunction

    function automatic word_t shift_in(
        input word_t word,
        input logic  b,
        input int    w,
        input logic  msb_first
    );
        word_t r;
        r = shift_out(word, msb_first);
        if (msb_first)
            r[0] = b;
        else
            r[IW'(w-1)] = b;
        return r;
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg: bit-order aware shift register with parallel load.
// Load and shift happen on the same edge: the loaded word is shifted once.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift_en,
    input  logic             din,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] pout,
    output logic             sout
);

    word_t src;
    word_t nxt;

    // next value: pick load source, then shift one place
    always_comb begin
        src  = word_t'(load ? pin : pout);
        nxt  = shift_in(src, din, WIDTH, MSB_FIRST);
        sout = first_bit(word_t'(pout), WIDTH, MSB_FIRST);
    end

    // register update on enabled edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pout <= '0;
        else if (shift_en)
            pout <= WIDTH'(nxt);
    end

endmodule

// File: rtl/spi_slave_word.sv
// spi_slave_word: full-duplex SPI slave clocked by sclk.
// Frame state is the bit counter itself: zero is IDLE, non-zero is SHIFT.
module spi_slave_word
    import spi_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    output logic             miso,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             busy
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] IDLE = '0;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    bit_cnt;
    logic             active;
    logic             idle;
    logic             last;
    logic [WIDTH-2:0] rx_q;
    logic             rx_sout;
    logic [WIDTH-1:0] tx_q;
    logic             tx_sout;
    logic [WIDTH-1:0] rx_word;
    logic             tx_first;

    // frame state decode and output muxing
    always_comb begin
        active   = ~cs_n;
        idle     = (bit_cnt == IDLE);
        last     = (bit_cnt == LAST);
        busy     = ~idle;
        rx_word  = MSB_FIRST ? {rx_q, mosi} : {mosi, rx_q};
        tx_first = first_bit(word_t'(tx_data), WIDTH, MSB_FIRST);
        miso     = rst_n & active & (idle ? tx_first : tx_sout);
    end

    spi_shift_reg #(
        .WIDTH     (WIDTH - 1),
        .MSB_FIRST (MSB_FIRST)
    ) u_rx (
        .clk      (sclk),
        .rst_n    (rst_n),
        .load     (1'b0),
        .shift_en (active),
        .din      (mosi),
        .pin      ('0),
        .pout     (rx_q),
        .sout     (rx_sout)
    );

    spi_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_tx (
        .clk      (sclk),
        .rst_n    (rst_n),
        .load     (idle),
        .shift_en (active),
        .din      (1'b0),
        .pin      (tx_data),
        .pout     (tx_q),
        .sout     (tx_sout)
    );

    // bit counter, receive word capture, strobes and frame count
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= IDLE;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (active) begin
                if (last) begin
                    bit_cnt   <= IDLE;
                    rx_data   <= rx_word;
                    rx_valid  <= 1'b1;
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end else begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end else if (!idle) begin
                bit_cnt   <= IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_word.sv
// tb_spi_slave_word: three DUT configurations against a frame-level model.
// Table vectors, hand-written corner sequences, then random traffic.
module tb_spi_slave_word;

    logic sclk  = 1'b0;
    logic rst_n = 1'b1;
    always #5 sclk = ~sclk;

    logic        cs [3];
    logic        mo [3];
    logic [15:0] tx [3];

    logic        miso_a, miso_b, miso_c;
    logic [7:0]  rxd_a, rxd_b;
    logic [11:0] rxd_c;
    logic        v_a, v_b, v_c;
    logic        e_a, e_b, e_c;
    logic [15:0] fc_a, fc_b;
    logic [1:0]  fc_c;
    logic        b_a, b_b, b_c;

    spi_slave_word #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(16)) dut_a (
        .sclk(sclk), .rst_n(rst_n), .cs_n(cs[0]), .mosi(mo[0]),
        .tx_data(tx[0][7:0]), .miso(miso_a), .rx_data(rxd_a),
        .rx_valid(v_a), .frame_err(e_a), .frame_cnt(fc_a), .busy(b_a)
    );

    spi_slave_word #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(16)) dut_b (
        .sclk(sclk), .rst_n(rst_n), .cs_n(cs[1]), .mosi(mo[1]),
        .tx_data(tx[1][7:0]), .miso(miso_b), .rx_data(rxd_b),
        .rx_valid(v_b), .frame_err(e_b), .frame_cnt(fc_b), .busy(b_b)
    );

    spi_slave_word #(.WIDTH(12), .MSB_FIRST(1'b1), .CNT_W(2)) dut_c (
        .sclk(sclk), .rst_n(rst_n), .cs_n(cs[2]), .mosi(mo[2]),
        .tx_data(tx[2][11:0]), .miso(miso_c), .rx_data(rxd_c),
        .rx_valid(v_c), .frame_err(e_c), .frame_cnt(fc_c), .busy(b_c)
    );

    int W   [3] = '{8, 8, 12};
    bit MS  [3] = '{1'b1, 1'b0, 1'b1};
    int CWm [3] = '{16, 16, 2};

    // frame-level model: bits collected per frame, word built at the end
    int          m_cnt [3];
    logic [15:0] m_tx  [3];
    logic [15:0] m_rx  [3];
    int          m_fc  [3];
    logic        m_v   [3];
    logic        m_e   [3];
    logic        acc   [3][16];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic get(input int d, output logic [15:0] rd,
                       output logic [15:0] fc, output logic v,
                       output logic e, output logic b, output logic m);
        case (d)
            0: begin rd = 16'(rxd_a); fc = fc_a; v = v_a; e = e_a;
                     b = b_a; m = miso_a; end
            1: begin rd = 16'(rxd_b); fc = fc_b; v = v_b; e = e_b;
                     b = b_b; m = miso_b; end
            default: begin rd = 16'(rxd_c); fc = 16'(fc_c); v = v_c;
                     e = e_c; b = b_c; m = miso_c; end
        endcase
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0; m_tx[d] = '0; m_rx[d] = '0;
            m_fc[d] = 0; m_v[d] = 1'b0; m_e[d] = 1'b0;
        end
    endtask

    function automatic logic m_miso(input int d);
        if (!rst_n || cs[d]) return 1'b0;
        if (m_cnt[d] == 0)
            return MS[d] ? tx[d][W[d]-1] : tx[d][0];
        return MS[d] ? m_tx[d][W[d]-1-m_cnt[d]] : m_tx[d][m_cnt[d]];
    endfunction

    task automatic model_edge();
        logic [15:0] w;
        for (int d = 0; d < 3; d++) begin
            m_v[d] = 1'b0;
            m_e[d] = 1'b0;
            if (!cs[d]) begin
                if (m_cnt[d] == 0) m_tx[d] = tx[d];
                acc[d][m_cnt[d]] = mo[d];
                m_cnt[d]++;
                if (m_cnt[d] == W[d]) begin
                    w = '0;
                    for (int i = 0; i < W[d]; i++)
                        if (MS[d]) w[W[d]-1-i] = acc[d][i];
                        else       w[i]        = acc[d][i];
                    m_rx[d]  = w;
                    m_v[d]   = 1'b1;
                    m_fc[d]  = (m_fc[d] + 1) % (1 << CWm[d]);
                    m_cnt[d] = 0;
                end
            end else begin
                m_e[d]   = (m_cnt[d] != 0);
                m_cnt[d] = 0;
            end
        end
    endtask

    task automatic check_miso();
        logic [15:0] rd, fc;
        logic v, e, b, m;
        for (int d = 0; d < 3; d++) begin
            get(d, rd, fc, v, e, b, m);
            chk($sformatf("miso%0d", d), 16'(m), 16'(m_miso(d)));
        end
    endtask

    task automatic check_regs();
        logic [15:0] rd, fc;
        logic v, e, b, m;
        for (int d = 0; d < 3; d++) begin
            get(d, rd, fc, v, e, b, m);
            chk($sformatf("rx_data%0d", d), rd, m_rx[d]);
            chk($sformatf("rx_valid%0d", d), 16'(v), 16'(m_v[d]));
            chk($sformatf("frame_err%0d", d), 16'(e), 16'(m_e[d]));
            chk($sformatf("frame_cnt%0d", d), fc, 16'(m_fc[d]));
            chk($sformatf("busy%0d", d), 16'(b), 16'(m_cnt[d] != 0));
        end
    endtask

    // called at a falling edge with inputs already driven
    task automatic tick();
        #1 check_miso();
        @(posedge sclk);
        if (rst_n) model_edge();
        @(negedge sclk);
        check_regs();
    endtask

    task automatic idle_all();
        for (int d = 0; d < 3; d++) cs[d] = 1'b1;
    endtask

    task automatic do_reset();
        idle_all();
        rst_n = 1'b0;
        #1 model_reset();
        check_regs();
        check_miso();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input int d, input logic [15:0] txw,
                              input logic [15:0] word, input int nb,
                              output logic [15:0] mseq);
        logic [15:0] rd, fc;
        logic v, e, b, m;
        mseq = '0;
        for (int i = 0; i < nb; i++) begin
            cs[d] = 1'b0;
            mo[d] = MS[d] ? word[W[d]-1-i] : word[i];
            tx[d] = (i == 0) ? txw : 16'($urandom);
            #1 get(d, rd, fc, v, e, b, m);
            mseq[i] = m;
            tick();
        end
    endtask

    typedef struct {
        int          d;
        logic [15:0] txw;
        logic [15:0] word;
        bit          b2b;
        logic [15:0] exp_rx;
        int          exp_fc;
        logic [15:0] exp_ms;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [15:0] rd, fc, ms;
        logic v, e, b, m;

        vecs[0] = '{0, 16'h096, 16'h0A5, 1'b0, 16'h0A5, 1, 16'h069};
        vecs[1] = '{1, 16'h03C, 16'h081, 1'b0, 16'h081, 1, 16'h03C};
        vecs[2] = '{0, 16'h000, 16'h012, 1'b1, 16'h012, 2, 16'h000};
        vecs[3] = '{0, 16'h000, 16'h034, 1'b0, 16'h034, 3, 16'h000};
        vecs[4] = '{2, 16'h000, 16'h123, 1'b0, 16'h123, 1, 16'h000};
        vecs[5] = '{2, 16'h000, 16'hFFF, 1'b0, 16'hFFF, 2, 16'h000};
        vecs[6] = '{2, 16'h000, 16'h000, 1'b1, 16'h000, 3, 16'h000};
        vecs[7] = '{2, 16'h000, 16'h5A5, 1'b0, 16'h5A5, 0, 16'h000};
        vecs[8] = '{2, 16'h000, 16'hABC, 1'b0, 16'hABC, 1, 16'h000};

        for (int d = 0; d < 3; d++) begin
            cs[d] = 1'b1; mo[d] = 1'b0; tx[d] = '0;
        end
        model_reset();
        #2 rst_n = 1'b0;
        @(negedge sclk);
        check_regs();
        check_miso();
        tick();
        rst_n = 1'b1;
        tick();

        // table-driven frames
        foreach (vecs[k]) begin
            send_frame(vecs[k].d, vecs[k].txw, vecs[k].word,
                       W[vecs[k].d], ms);
            get(vecs[k].d, rd, fc, v, e, b, m);
            chk($sformatf("vec%0d rx_data", k), rd, vecs[k].exp_rx);
            chk($sformatf("vec%0d rx_valid", k), 16'(v), 16'd1);
            chk($sformatf("vec%0d frame_cnt", k), fc, 16'(vecs[k].exp_fc));
            chk($sformatf("vec%0d miso_seq", k), ms, vecs[k].exp_ms);
            if (!vecs[k].b2b) begin
                cs[vecs[k].d] = 1'b1;
                tick();
                get(vecs[k].d, rd, fc, v, e, b, m);
                chk($sformatf("vec%0d strobe_drop", k), 16'(v), 16'd0);
            end
        end

        // deselect after five bits, then a full frame
        do_reset();
        tick();
        send_frame(0, 16'h000, 16'h0F0, 5, ms);
        cs[0] = 1'b1;
        tick();
        get(0, rd, fc, v, e, b, m);
        chk("abort frame_err", 16'(e), 16'd1);
        chk("abort rx_data", rd, 16'h000);
        chk("abort frame_cnt", fc, 16'd0);
        chk("abort rx_valid", 16'(v), 16'd0);
        tick();
        get(0, rd, fc, v, e, b, m);
        chk("abort err_drop", 16'(e), 16'd0);
        send_frame(0, 16'h000, 16'h0FF, 8, ms);
        get(0, rd, fc, v, e, b, m);
        chk("after_abort rx_data", rd, 16'h0FF);
        chk("after_abort frame_cnt", fc, 16'd1);
        cs[0] = 1'b1;
        tick();

        // asynchronous reset in the middle of a frame
        send_frame(0, 16'h0FF, 16'h0E0, 3, ms);
        tx[0] = 16'h0FF;
        rst_n = 1'b0;
        #1 get(0, rd, fc, v, e, b, m);
        chk("rst rx_data", rd, 16'h000);
        chk("rst frame_cnt", fc, 16'd0);
        chk("rst busy", 16'(b), 16'd0);
        chk("rst miso", 16'(m), 16'd0);
        chk("rst err", 16'(e), 16'd0);
        model_reset();
        idle_all();
        tick();
        rst_n = 1'b1;
        tick();
        get(0, rd, fc, v, e, b, m);
        chk("post_rst err", 16'(e), 16'd0);
        send_frame(0, 16'h000, 16'h05A, 8, ms);
        get(0, rd, fc, v, e, b, m);
        chk("post_rst rx_data", rd, 16'h05A);
        chk("post_rst frame_cnt", fc, 16'd1);

        // random traffic on all three slaves at once
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 3; d++) begin
                cs[d] = ($urandom_range(0, 9) == 0);
                mo[d] = 1'($urandom);
                tx[d] = 16'($urandom);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_slave_word.md
# spi_slave_word

Parametrised full-duplex SPI slave clocked directly by the serial clock `sclk`. Frames are delimited by `cs_n`. The block shifts in `WIDTH`-bit words on `mosi` and shifts out a parallel transmit word on `miso`. It presents each completed receive word with a one-cycle valid strobe, counts completed frames, and flags frames aborted by early deselect. It is the generalised successor to the fixed 8-bit receive-only slave and feeds the indicator/register logic in the `sclk` domain.

## Interface
- `WIDTH`, 8: bits per frame, ≥2
- `MSB_FIRST`, 1: 1 = MSB shifted first on both `mosi` and `miso`; 0 = LSB first
- `CNT_W`, 16: width of frame counter
- `sclk`  in  1  serial clock, only clock; all state changes on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `cs_n`  in  1  chip select, active low, sampled on `sclk` rising edge
- `mosi`  in  1  serial data in, sampled on `sclk` rising edge
- `tx_data`  in  WIDTH  word to transmit, sampled at the first bit of each frame
- `miso`  out  1  serial data out
- `rx_data`  out  WIDTH  last complete received word, held until next completed frame
- `rx_valid`  out  1  one-cycle strobe: `rx_data` updated this cycle
- `frame_err`  out  1  one-cycle strobe: frame aborted by `cs_n` high mid-frame
- `frame_cnt`  out  CNT_W  completed frames, wraps modulo 2^CNT_W
- `busy`  out  1  high while `bit_cnt != 0`

## Operation
- Internal state:
  - `bit_cnt`, range 0..WIDTH-1, width `$clog2(WIDTH)`
  - `rx_shift`, WIDTH-1 bits
  - `tx_shift`, WIDTH bits
- Active edge: rising `sclk` with `cs_n` = 0.
  - `mosi` enters `rx_shift` at the end selected by `MSB_FIRST`.
  - `bit_cnt` increments.
- Frame complete: active edge with `bit_cnt` = WIDTH-1.
  - `rx_data` <= `rx_shift` merged with the current `mosi` bit into the correctly ordered word.
  - `rx_valid` = 1 for the following cycle.
  - `bit_cnt` <= 0 and `frame_cnt` += 1.
  - A frame takes exactly WIDTH active edges; there is no idle/load cycle between back-to-back frames.
- Transmit:
  - While `bit_cnt` = 0, `miso` = first bit of `tx_data` (combinational). Otherwise `miso` = first bit of `tx_shift`.
  - On every active edge, `tx_shift` <= (`bit_cnt` = 0 ? `tx_data` : `tx_shift`), shifted by one toward the output end.
  - `tx_data` changes after the first edge of a frame do not affect that frame.
- Deselect: rising edge with `cs_n` = 1.
  - If `bit_cnt` ≠ 0: `frame_err` = 1 for the following cycle, `bit_cnt` <= 0, partial word discarded. `rx_data` and `frame_cnt` are unchanged and `rx_valid` stays 0.
  - If `bit_cnt` = 0: nothing changes.
- `miso` = 0 whenever `cs_n` = 1. There is no tristate; pad-level gating is external.
- `rx_valid` and `frame_err` are never high in the same cycle.

## Timing
- Reset (`rst_n` = 0, asynchronous, any time including mid-frame): `bit_cnt`, `rx_shift`, `tx_shift`, `rx_data`, `frame_cnt` = 0; `rx_valid`, `frame_err`, `busy`, `miso` = 0.
  - Partial frame is lost silently, with no `frame_err`.
  - Release is synchronous to `sclk`; the first active edge after release is bit 0.
- Latency: `rx_data`/`rx_valid` valid after the WIDTH-th active edge of the frame. Strobes are registered and last exactly one `sclk` cycle.
- `frame_cnt` wraps from 2^CNT_W-1 to 0 with no flag.
- Caveat: with `sclk` stopped, strobes and deselect detection stall. Consumers must sample on `sclk` or tolerate a held strobe.
- State machine: IDLE (`bit_cnt` = 0) and SHIFT (`bit_cnt` ≠ 0). It is encoded by `bit_cnt`; no separate state register.

## Structure
- Package `spi_pkg`:
  - `localparam` helpers: counter width `$clog2(WIDTH)`
  - function `first_bit(word, msb_first)`
  - function `shift_in(word, bit, msb_first)`
  - function `shift_out(word, msb_first)`
- Sub-module `spi_shift_reg` (params WIDTH, MSB_FIRST; ports: `load`, `shift_en`, `din`, `pin`, `pout`, `sout`). Instantiated twice, once for rx and once for tx.
- Top level holds `bit_cnt`, strobes, `frame_cnt` and `cs_n` handling.

## Test plan
- WIDTH=8, MSB_FIRST=1, one frame `mosi` = 0xA5 -> `rx_data` = 0xA5, `rx_valid` high exactly one cycle after edge 8, `frame_cnt` = 1.
- WIDTH=8, MSB_FIRST=0, `tx_data` = 0x3C, `mosi` = 0x81 -> `miso` sequence 0,0,1,1,1,1,0,0; `rx_data` = 0x81.
- Back-to-back 0x12, 0x34 with `cs_n` held low for 16 edges -> two `rx_valid` strobes 8 edges apart, `rx_data` 0x12 then 0x34, `frame_cnt` = 2.
- `cs_n` high after 5 bits, then full frame 0xFF -> `frame_err` one cycle, `rx_data` stays 0 until 0xFF arrives, `frame_cnt` = 1.
- `rst_n` pulsed low after 3 bits -> all outputs 0 immediately, no `frame_err`; next 8 bits 0x5A -> `rx_data` = 0x5A.
- CNT_W=2, five frames -> `frame_cnt` 1,2,3,0,1; WIDTH=12 frame 0xABC -> `rx_data` = 0xABC.
